usb_cmd_rx: RTL and testbench

- Host-to-FPGA command receiver on the FT245 read path. Consumes the byte stream the host writes through the FT2232H read FIFO.
- Parses fixed 5-byte write frames and updates a bank of 16-bit configuration registers (ADC channel select, FFT/FIR mode, ADF4158 ramp options).
- Returns a one-byte ACK/NAK to the host through the FT245 write FIFO.
- Sits in the clk_i (40 MHz) domain, beside the ft245 instance.

---
 rtl/usb_cmd_rx.sv | 121 ++++++++++++
 tb/tb_usb_cmd_rx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_rx.sv
// usb_cmd_rx: host command receiver on the FT245 read path.
// Parses SYNC/ADDR/DHI/DLO/CSUM write frames into a bank of 16-bit
// configuration registers and answers each complete frame with ACK/NAK.
module usb_cmd_rx #(
  parameter int          NUM_REGS  = 8,
  parameter int          TIMEOUT   = 4000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rd_data,
  input  logic                     rd_empty,
  output logic                     rd_en,
  output logic [7:0]               tx_data,
  output logic                     tx_wren,
  input  logic                     tx_full,
  output logic [16*NUM_REGS-1:0]   regs_o,
  output logic                     wr_stb_o,
  output logic [7:0]               wr_addr_o,
  output logic [7:0]               err_cnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {HUNT, ADDR, DHI, DLO, CSUM, RESP} state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] dhi;
    logic [7:0] dlo;
  } frame_t;

  state_t                     state;
  frame_t                     frm;
  logic                       inflight;   // rd_en was high last cycle; rd_data valid now
  logic [CW-1:0]              to_cnt;
  logic [7:0]                 resp;
  logic [NUM_REGS-1:0][15:0]  regs;

  logic mid_frame, to_hit, csum_ok, addr_ok;

  assign mid_frame = (state == ADDR) || (state == DHI) || (state == DLO) || (state == CSUM);
  assign to_hit    = mid_frame && (to_cnt == CW'(TIMEOUT - 1));
  assign csum_ok   = (rd_data == (frm.addr ^ frm.dhi ^ frm.dlo));
  assign addr_ok   = (int'(frm.addr) < NUM_REGS);

  // Pop only with nothing in flight, never while a response is pending,
  // and not on the cycle the frame is being abandoned for timeout.
  assign rd_en  = !rst && !rd_empty && !inflight && (state != RESP) && !to_hit;
  assign regs_o = regs;

  // Frame parser, register bank, response and error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      frm       <= '0;
      inflight  <= 1'b0;
      to_cnt    <= '0;
      resp      <= '0;
      regs      <= '0;
      tx_data   <= '0;
      tx_wren   <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      err_cnt_o <= '0;
    end else begin
      inflight <= rd_en;
      wr_stb_o <= 1'b0;
      tx_wren  <= 1'b0;
      if (to_hit) begin
        // Partial frame dropped; any byte landing this cycle is discarded.
        state  <= HUNT;
        to_cnt <= '0;
        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end else begin
        case (state)
          HUNT: begin
            to_cnt <= '0;
            if (inflight && rd_data == SYNC_BYTE) state <= ADDR;
          end
          ADDR, DHI, DLO, CSUM: begin
            if (inflight) begin
              to_cnt <= '0;
              case (state)
                ADDR: begin frm.addr <= rd_data; state <= DHI;  end
                DHI:  begin frm.dhi  <= rd_data; state <= DLO;  end
                DLO:  begin frm.dlo  <= rd_data; state <= CSUM; end
                default: begin
                  if (csum_ok && addr_ok) begin
                    regs[frm.addr[IW-1:0]] <= {frm.dhi, frm.dlo};
                    wr_stb_o  <= 1'b1;
                    wr_addr_o <= frm.addr;
                    resp      <= ACK_BYTE;
                  end else begin
                    resp <= NAK_BYTE;
                    if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                  end
                  state <= RESP;
                end
              endcase
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          RESP: begin
            if (!tx_full) begin
              tx_wren <= 1'b1;
              tx_data <= resp;
              state   <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_cmd_rx.sv
// tb_usb_cmd_rx: directed + randomized bench for usb_cmd_rx with a
// frame-level reference model fed from an emulated FT245 read FIFO.
module tb_usb_cmd_rx;
  localparam int NR = 8;
  localparam int TO = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rd_data;
  logic              rd_empty;
  logic              rd_en;
  logic [7:0]        tx_data;
  logic              tx_wren;
  logic              tx_full;
  logic [16*NR-1:0]  regs_o;
  logic              wr_stb_o;
  logic [7:0]        wr_addr_o;
  logic [7:0]        err_cnt_o;

  always #5 clk = ~clk;

  usb_cmd_rx #(.NUM_REGS(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rd_data(rd_data), .rd_empty(rd_empty), .rd_en(rd_en),
    .tx_data(tx_data), .tx_wren(tx_wren), .tx_full(tx_full), .regs_o(regs_o),
    .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o), .err_cnt_o(err_cnt_o)
  );

  int checks = 0, failures = 0;

  // model state
  logic [7:0]  fifo_q[$];
  logic [7:0]  resp_q[$];
  logic [23:0] wr_q[$];
  logic [15:0] mregs[NR];
  logic [7:0]  mf[4];
  int          merr, mpos, tx_count;
  logic [7:0]  last_tx;
  bit          awaiting, rand_full;
  logic        full_prev, rden_prev;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [16*NR-1:0] act, input logic [16*NR-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: frame rules applied to each byte as it leaves the FIFO.
  task automatic model_byte(input logic [7:0] b);
    if (mpos == 0) begin
      if (b == 8'hA5) mpos = 1;
    end else begin
      mf[mpos-1] = b;
      mpos++;
      if (mpos == 5) begin
        mpos = 0;
        awaiting = 1'b1;
        if (mf[3] == (mf[0] ^ mf[1] ^ mf[2]) && int'(mf[0]) < NR) begin
          wr_q.push_back({mf[0], mf[1], mf[2]});
          resp_q.push_back(8'h06);
        end else begin
          resp_q.push_back(8'h15);
          if (merr < 255) merr++;
        end
      end
    end
  endtask

  task automatic model_reset();
    foreach (mregs[k]) mregs[k] = '0;
    merr = 0; mpos = 0; awaiting = 1'b0;
    resp_q.delete(); wr_q.delete();
  endtask

  function automatic logic [16*NR-1:0] mvec();
    logic [16*NR-1:0] v;
    for (int k = 0; k < NR; k++) v[16*k +: 16] = mregs[k];
    return v;
  endfunction

  // Compare process and read-FIFO emulation, both on the falling edge.
  initial begin
    logic [23:0] e;
    logic [7:0]  b;
    full_prev = 1'b0; rden_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rden_prev = 1'b0;
        full_prev = tx_full;
      end else begin
        if (tx_wren) begin
          tx_count++;
          last_tx = tx_data;
          chk1("tx_wren_while_full", full_prev, 1'b0);
          if (resp_q.size() == 0) begin
            failures++; checks++;
            $display("FAIL unexpected_tx actual=%0h required=none", tx_data);
          end else chk8("tx_data", tx_data, resp_q.pop_front());
          awaiting = 1'b0;
          chk8("err_at_resp", err_cnt_o, 8'(merr));
        end
        if (wr_stb_o) begin
          if (wr_q.size() == 0) begin
            failures++; checks++;
            $display("FAIL unexpected_wr_stb actual=%0h required=none", wr_addr_o);
          end else begin
            e = wr_q.pop_front();
            chk8("wr_addr", wr_addr_o, e[23:16]);
            mregs[e[23:16]] = e[15:0];
          end
        end
        chkw("regs", regs_o, mvec());
        if (rd_en) begin
          chk1("rd_en_when_empty", rd_empty, 1'b0);
          chk1("rd_en_back_to_back", rden_prev, 1'b0);
          chk1("rd_en_while_resp_pending", awaiting, 1'b0);
          if (fifo_q.size() != 0) begin
            b = fifo_q.pop_front();
            rd_data = b;
            model_byte(b);
          end
        end
        rden_prev = rd_en;
        full_prev = tx_full;
      end
    end
  end

  // FIFO empty flag and random write-FIFO backpressure change just after the edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      rd_empty = (fifo_q.size() == 0);
      if (rand_full) tx_full = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push5(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
    fifo_q.push_back(8'hA5); fifo_q.push_back(a); fifo_q.push_back(h);
    fifo_q.push_back(l);     fifo_q.push_back(c);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((fifo_q.size() != 0 || resp_q.size() != 0 || wr_q.size() != 0) && n < bound) begin
      tick(1); n++;
    end
    checks++;
    if (n >= bound) begin
      failures++;
      $display("FAIL idle_wait actual=busy required=idle_within_%0d", bound);
    end
    tick(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick(2);
    rst = 1'b0;
    chk1("rst_rd_en", rd_en, 1'b0);
    chk1("rst_tx_wren", tx_wren, 1'b0);
    chk8("rst_tx_data", tx_data, 8'h00);
    chk1("rst_wr_stb", wr_stb_o, 1'b0);
    chk8("rst_wr_addr", wr_addr_o, 8'h00);
    chk8("rst_err_cnt", err_cnt_o, 8'h00);
    chkw("rst_regs", regs_o, '0);
  endtask

  initial begin
    int t0;
    logic [7:0] a, h, l, j;
    rst = 1'b1; tx_full = 1'b0; rd_empty = 1'b1; rd_data = 8'h00;
    rand_full = 1'b0; tx_count = 0; last_tx = 8'h00;
    model_reset();
    tick(2);
    do_reset();

    // valid write to reg 3
    t0 = tx_count;
    push5(8'h03, 8'h12, 8'h34, 8'h25);
    wait_idle(500);
    chk16("w3_reg", regs_o[63:48], 16'h1234);
    chk8("w3_addr", wr_addr_o, 8'h03);
    chki("w3_tx_count", tx_count - t0, 1);
    chk8("w3_ack", last_tx, 8'h06);
    chk8("w3_err", err_cnt_o, 8'h00);

    // bad checksum
    push5(8'h03, 8'h12, 8'h34, 8'h26);
    wait_idle(500);
    chk16("badcs_reg", regs_o[63:48], 16'h1234);
    chk8("badcs_nak", last_tx, 8'h15);
    chk8("badcs_err", err_cnt_o, 8'h01);

    // out-of-range address
    do_reset();
    push5(8'h09, 8'h00, 8'h01, 8'h08);
    wait_idle(500);
    chk8("oor_nak", last_tx, 8'h15);
    chk8("oor_err", err_cnt_o, 8'h01);
    chkw("oor_regs", regs_o, '0);

    // backpressure with a second frame queued behind
    t0 = tx_count;
    tx_full = 1'b1;
    push5(8'h04, 8'hBE, 8'hEF, 8'h55);
    push5(8'h05, 8'h00, 8'h7F, 8'h7A);
    tick(50);
    chki("bp_no_tx", tx_count - t0, 0);
    chki("bp_second_frame_held", fifo_q.size(), 5);
    tx_full = 1'b0;
    wait_idle(500);
    chki("bp_tx_count", tx_count - t0, 2);
    chk16("bp_reg4", regs_o[79:64], 16'hBEEF);
    chk16("bp_reg5", regs_o[95:80], 16'h007F);

    // junk then partial frame timeout
    do_reset();
    t0 = tx_count;
    fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h05);
    wait_idle(500);
    chki("to_model_pos", mpos, 2);
    tick(TO + 10);
    if (mpos != 0) begin mpos = 0; if (merr < 255) merr++; end
    chk8("to_err", err_cnt_o, 8'h01);
    chki("to_no_tx", tx_count - t0, 0);
    chkw("to_regs", regs_o, '0);
    push5(8'h01, 8'hAB, 8'hCD, 8'h67);
    wait_idle(500);
    chk16("to_next_reg1", regs_o[31:16], 16'hABCD);
    chk8("to_next_ack", last_tx, 8'h06);

    // reset mid-frame
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h02); fifo_q.push_back(8'h11);
    wait_idle(500);
    do_reset();
    t0 = tx_count;
    fifo_q.push_back(8'h22); fifo_q.push_back(8'h31);
    wait_idle(500);
    chki("mid_rst_no_tx", tx_count - t0, 0);
    push5(8'h02, 8'h11, 8'h22, 8'h31);
    wait_idle(500);
    chk16("mid_rst_reg2", regs_o[47:32], 16'h1122);
    chki("mid_rst_tx_count", tx_count - t0, 1);

    // randomized frames with random backpressure
    rand_full = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int kind;
      kind = $urandom_range(0, 4);
      a = 8'($urandom_range(0, NR - 1));
      h = 8'($urandom); l = 8'($urandom);
      if (kind == 3) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) begin
          j = 8'($urandom);
          if (j == 8'hA5) j = 8'h00;
          fifo_q.push_back(j);
        end
      end
      if (kind == 4) h = 8'hA5;
      if (kind == 2) a = 8'($urandom_range(NR, 255));
      fifo_q.push_back(8'hA5);
      tick($urandom_range(0, 3));
      fifo_q.push_back(a);
      tick($urandom_range(0, 3));
      fifo_q.push_back(h);
      tick($urandom_range(0, 3));
      fifo_q.push_back(l);
      tick($urandom_range(0, 3));
      fifo_q.push_back((kind == 1) ? (a ^ h ^ l ^ 8'(1 + $urandom_range(0, 254))) : (a ^ h ^ l));
      tick($urandom_range(0, 6));
    end
    wait_idle(20000);
    rand_full = 1'b0;
    tx_full = 1'b0;
    tick(2);
    chk8("rand_err", err_cnt_o, 8'(merr));

    // error counter saturation
    for (int f = 0; f < 260; f++) push5(8'h00, 8'h00, 8'h00, 8'h01);
    wait_idle(20000);
    chk8("sat_err", err_cnt_o, 8'hFF);
    chki("end_wr_q_empty", wr_q.size(), 0);
    chki("end_resp_q_empty", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
